// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-to-1 multiplexer with built-in round-robin or
// fixed-priority arbitration and valid/ready handshakes on both sides.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_data_bus    flattened channel data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_valid       per-channel request valid
//   o_in_ready    per-channel accept strobe (combinational, one-hot or zero)
//   i_fixed_prio  1 = lowest index wins, 0 = round-robin
//   o_valid       output register holds a valid word
//   i_ready       consumer accepts the output word this cycle
//   o_data        registered data of the granted channel
//   o_grant_idx   index of the channel that produced o_data
module rr_arb_mux #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned IDX_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
  input  logic [NUM_INPUTS-1:0]            i_valid,
  output logic [NUM_INPUTS-1:0]            o_in_ready,
  input  logic                             i_fixed_prio,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [IDX_WIDTH-1:0]             o_grant_idx
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

  logic [IDX_WIDTH-1:0]  r_ptr;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IDX_WIDTH-1:0]  r_grant_idx;

  logic                  w_any;
  logic                  w_load_en;
  logic                  w_xfer;
  logic [IDX_WIDTH-1:0]  w_winner;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [NUM_INPUTS-1:0] w_in_ready;

  assign w_any     = |i_valid;
  assign w_load_en = !r_valid || i_ready;
  // A transfer happens exactly when the winner's ready strobe is raised.
  assign w_xfer    = i_rst_n && w_load_en && w_any;

  // Scan channels starting at 0 (fixed) or at r_ptr (round-robin), wrapping
  // explicitly so non-power-of-2 channel counts never index past the end.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    logic        found;
    w_winner   = '0;
    w_sel_data = '0;
    found      = 1'b0;
    base       = i_fixed_prio ? 0 : int'(r_ptr);
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      idx = base + i;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!found && i_valid[idx]) begin
        found      = 1'b1;
        w_winner   = IDX_WIDTH'(idx);
        w_sel_data = i_data_bus[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Accept strobe: only the winner, only when the output register can load.
  always_comb begin
    w_in_ready = '0;
    if (w_xfer) w_in_ready[w_winner] = 1'b1;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_grant_idx <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_valid     <= 1'b1;
        r_data      <= w_sel_data;
        r_grant_idx <= w_winner;
        if (!i_fixed_prio)
          r_ptr <= (w_winner == LAST_IDX) ? '0 : w_winner + IDX_WIDTH'(1);
      end else begin
        // Drained with nothing to replace it: data and index hold.
        r_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_grant_idx = r_grant_idx;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed bench for rr_arb_mux with a 4-channel and a
// 3-channel instance sharing clock and reset.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n;

  // 4-channel instance
  logic [31:0] data4;
  logic [3:0]  valid4;
  logic [3:0]  in_ready4;
  logic        fixed4;
  logic        ovalid4;
  logic        ready4;
  logic [7:0]  odata4;
  logic [1:0]  idx4;

  // 3-channel instance
  logic [23:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  in_ready3;
  logic        fixed3;
  logic        ovalid3;
  logic        ready3;
  logic [7:0]  odata3;
  logic [1:0]  idx3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.NUM_INPUTS(4), .DATA_WIDTH(8)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_bus(data4), .i_valid(valid4),
    .o_in_ready(in_ready4), .i_fixed_prio(fixed4), .o_valid(ovalid4),
    .i_ready(ready4), .o_data(odata4), .o_grant_idx(idx4)
  );

  rr_arb_mux #(.NUM_INPUTS(3), .DATA_WIDTH(8)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_bus(data3), .i_valid(valid3),
    .o_in_ready(in_ready3), .i_fixed_prio(fixed3), .o_valid(ovalid3),
    .i_ready(ready3), .o_data(odata3), .o_grant_idx(idx3)
  );

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    valid4 = 4'b1111; ready4 = 1'b1; fixed4 = 1'b0;
    valid3 = 3'b000;  ready3 = 1'b1; fixed3 = 1'b0;
    #1;
    n_vec++;
    if (in_ready4 !== 4'b0000) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready4);
    end
    tick(); tick();
    n_vec++;
    if (ovalid4 !== 1'b0 || odata4 !== 8'h00 || idx4 !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h i=%0d want v=0 d=00 i=0", ovalid4, odata4, idx4);
    end
    n_vec++;
    if (ovalid3 !== 1'b0 || odata3 !== 8'h00 || idx3 !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state3: got v=%b d=%h i=%0d want v=0 d=00 i=0", ovalid3, odata3, idx3);
    end
  endtask

  // Only channel 2 requests; then the drain with no requests must clear o_valid only.
  task automatic test_single();
    valid4 = 4'b0000;
    rst_n  = 1'b1;
    tick();
    valid4 = 4'b0100;
    #1;
    n_vec++;
    if (in_ready4 !== 4'b0100) begin
      n_err++; $display("FAIL single_in_ready: got %b want 0100", in_ready4);
    end
    tick();
    n_vec++;
    if (ovalid4 !== 1'b1 || odata4 !== 8'hBB || idx4 !== 2'd2) begin
      n_err++;
      $display("FAIL single_out: got v=%b d=%h i=%0d want v=1 d=bb i=2", ovalid4, odata4, idx4);
    end
    valid4 = 4'b0000;
    tick();
    n_vec++;
    if (ovalid4 !== 1'b0 || odata4 !== 8'hBB || idx4 !== 2'd2) begin
      n_err++;
      $display("FAIL idle_hold: got v=%b d=%h i=%0d want v=0 d=bb i=2", ovalid4, odata4, idx4);
    end
  endtask

  // Load BB (pointer is at 3, channel 2 still wins), then reset for one cycle.
  task automatic test_reset_midstream();
    valid4 = 4'b0100;
    tick();
    n_vec++;
    if (ovalid4 !== 1'b1 || odata4 !== 8'hBB) begin
      n_err++; $display("FAIL mid_preload: got v=%b d=%h want v=1 d=bb", ovalid4, odata4);
    end
    rst_n  = 1'b0;
    valid4 = 4'b1111;
    #1;
    n_vec++;
    if (in_ready4 !== 4'b0000) begin
      n_err++; $display("FAIL mid_in_ready: got %b want 0000", in_ready4);
    end
    tick();
    n_vec++;
    if (ovalid4 !== 1'b0 || odata4 !== 8'h00 || idx4 !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b d=%h i=%0d want v=0 d=00 i=0", ovalid4, odata4, idx4);
    end
  endtask

  // All channels request with pointer freshly reset to 0.
  task automatic test_round_robin();
    logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_dat [5] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'hDD};
    rst_n  = 1'b1;
    valid4 = 4'b1111; ready4 = 1'b1; fixed4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (in_ready4 !== (4'b0001 << exp_idx[i])) begin
        n_err++; $display("FAIL rr_in_ready[%0d]: got %b want idx %0d", i, in_ready4, exp_idx[i]);
      end
      tick();
      n_vec++;
      if (ovalid4 !== 1'b1 || idx4 !== exp_idx[i] || odata4 !== exp_dat[i]) begin
        n_err++;
        $display("FAIL rr_out[%0d]: got v=%b i=%0d d=%h want v=1 i=%0d d=%h",
                 i, ovalid4, idx4, odata4, exp_idx[i], exp_dat[i]);
      end
    end
  endtask

  // Pointer enters at 1. Schedule of (fixed, expected grant):
  // fixed x3 -> 1; rr -> 1 (ptr 2); fixed -> 1 (ptr holds 2); rr x3 -> 3,1,3.
  task automatic test_fixed_prio();
    logic       mode    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] exp_idx [8] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd3};
    valid4 = 4'b1010; ready4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fixed4 = mode[i];
      tick();
      n_vec++;
      if (ovalid4 !== 1'b1 || idx4 !== exp_idx[i] ||
          odata4 !== ((exp_idx[i] == 2'd3) ? 8'hAA : 8'hCC)) begin
        n_err++;
        $display("FAIL prio[%0d]: got v=%b i=%0d d=%h want i=%0d", i, ovalid4, idx4, odata4, exp_idx[i]);
      end
    end
    fixed4 = 1'b0;
  endtask

  // Pointer enters at 0; load CC from channel 1 (ptr -> 2), then stall.
  task automatic test_back_pressure();
    valid4 = 4'b0010; ready4 = 1'b1;
    tick();
    n_vec++;
    if (ovalid4 !== 1'b1 || odata4 !== 8'hCC || idx4 !== 2'd1) begin
      n_err++; $display("FAIL bp_load: got v=%b d=%h i=%0d want v=1 d=cc i=1", ovalid4, odata4, idx4);
    end
    valid4 = 4'b1111; ready4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (in_ready4 !== 4'b0000) begin
        n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready4);
      end
      tick();
      n_vec++;
      if (ovalid4 !== 1'b1 || odata4 !== 8'hCC || idx4 !== 2'd1) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h i=%0d want v=1 d=cc i=1", i, ovalid4, odata4, idx4);
      end
    end
    ready4 = 1'b1;
    #1;
    n_vec++;
    if (in_ready4 !== 4'b0100) begin
      n_err++; $display("FAIL bp_release_in_ready: got %b want 0100", in_ready4);
    end
    tick();
    n_vec++;
    if (ovalid4 !== 1'b1 || odata4 !== 8'hBB || idx4 !== 2'd2) begin
      n_err++; $display("FAIL bp_release: got v=%b d=%h i=%0d want v=1 d=bb i=2", ovalid4, odata4, idx4);
    end
    valid4 = 4'b0000;
  endtask

  // Three channels: pointer must wrap from 2 to 0, never reaching index 3.
  task automatic test_npot();
    logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [7:0] exp_dat [5] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
    valid3 = 3'b111; ready3 = 1'b1; fixed3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (in_ready3 !== (3'b001 << exp_idx[i])) begin
        n_err++; $display("FAIL npot_in_ready[%0d]: got %b want idx %0d", i, in_ready3, exp_idx[i]);
      end
      tick();
      n_vec++;
      if (ovalid3 !== 1'b1 || idx3 !== exp_idx[i] || odata3 !== exp_dat[i]) begin
        n_err++;
        $display("FAIL npot_out[%0d]: got v=%b i=%0d d=%h want v=1 i=%0d d=%h",
                 i, ovalid3, idx3, odata3, exp_idx[i], exp_dat[i]);
      end
    end
    valid3 = 3'b000;
  endtask

  initial begin
    data4  = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    data3  = {8'h33, 8'h22, 8'h11};
    rst_n  = 1'b0;
    valid4 = '0; ready4 = 1'b0; fixed4 = 1'b0;
    valid3 = '0; ready3 = 1'b0; fixed3 = 1'b0;
    test_reset();
    test_single();
    test_reset_midstream();
    test_round_robin();
    test_fixed_prio();
    test_back_pressure();
    test_npot();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
